// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter and its barrel shifter.
// Opcodes, datapath widths, the S1 state encoding and the bit-reversal helper.
package shift_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S1_EMPTY  = 2'd0,
    S1_SHIFT  = 2'd1,
    S1_ROT_LO = 2'd2,
    S1_ROT_HI = 2'd3
  } s1_state_t;

  function automatic logic [DATA_W-1:0] bit_rev32(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/Shifter.sv
// Shared 32-bit logical-right barrel shifter; zero fill.
// Every other shift flavour is built around it by the arbiter.
module Shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] dataA,
  input  logic [AMT_W-1:0]  dataB,
  output logic [DATA_W-1:0] dataOut
);
  assign dataOut = dataA >> dataB;
endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one right shifter: S1 = operands + shifter, S2 = response register.
// state     | meaning
// EMPTY     | S1 holds no operation
// SHIFT     | single-pass SRL/SLL/SRA result ready to move to S2
// ROT_LO    | first ROR pass, capturing the right-shifted half
// ROT_HI    | second ROR pass, merging the left-shifted half
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [AMT_W-1:0]  req_amt0,
  input  logic [AMT_W-1:0]  req_amt1,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id
);
  s1_state_t         state, state_nxt;
  logic [DATA_W-1:0] data_q, partial_q;
  logic [AMT_W-1:0]  amt_q, sh_amt;
  logic [1:0]        op_q;
  logic              id_q, last_q;

  logic              gnt, accept, s2_can_load, s1_done, s1_can_load;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic [1:0]        sel_op;
  logic              use_rev, use_inv;
  logic [DATA_W-1:0] sh_in, sh_out, sh_res, s1_result;

  assign s2_can_load = !resp_valid || resp_ready;
  assign s1_done     = ((state == S1_SHIFT) || (state == S1_ROT_HI)) && s2_can_load;
  assign s1_can_load = (state == S1_EMPTY) || s1_done;

  // Only one port valid: that port wins; both valid: alternate or favour port 0.
  assign gnt       = (&req_valid) ? (RR_EN ? ~last_q : 1'b0) : req_valid[1];
  assign req_ready = (!rst && s1_can_load && (|req_valid)) ? (2'b01 << gnt) : 2'b00;
  assign accept    = |req_ready;

  assign sel_data = gnt ? req_data1 : req_data0;
  assign sel_amt  = gnt ? req_amt1  : req_amt0;
  assign sel_op   = gnt ? req_op1   : req_op0;

  always_comb begin
    use_rev = 1'b0;
    use_inv = 1'b0;
    sh_amt  = amt_q;
    case (state)
      S1_SHIFT: begin
        use_rev = (op_q == OP_SLL);
        use_inv = (op_q == OP_SRA) && data_q[DATA_W-1];
      end
      S1_ROT_HI: begin
        use_rev = 1'b1;
        sh_amt  = ~amt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Left shifts run reversed; negative SRA runs inverted so zero fill becomes sign fill.
  assign sh_in     = use_rev ? bit_rev32(data_q) : (use_inv ? ~data_q : data_q);
  assign sh_res    = use_rev ? bit_rev32(sh_out) : (use_inv ? ~sh_out : sh_out);
  assign s1_result = (state == S1_ROT_HI) ? (partial_q | sh_res) : sh_res;

  Shifter u_shifter (
    .dataA   (sh_in),
    .dataB   (sh_amt),
    .dataOut (sh_out)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S1_EMPTY: if (accept) state_nxt = (sel_op == OP_ROR) ? S1_ROT_LO : S1_SHIFT;
      S1_ROT_LO: state_nxt = S1_ROT_HI;
      S1_SHIFT, S1_ROT_HI: begin
        if (s2_can_load) begin
          if (accept) state_nxt = (sel_op == OP_ROR) ? S1_ROT_LO : S1_SHIFT;
          else        state_nxt = S1_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S1_EMPTY;
      data_q     <= '0;
      amt_q      <= '0;
      op_q       <= OP_SRL;
      id_q       <= 1'b0;
      partial_q  <= '0;
      last_q     <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q <= sel_data;
        amt_q  <= sel_amt;
        op_q   <= sel_op;
        id_q   <= gnt;
        last_q <= gnt;
      end
      if (state == S1_ROT_LO) partial_q <= sh_res;
      if (s1_done) begin
        resp_valid <= 1'b1;
        resp_data  <= s1_result;
        resp_id    <= id_q;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed cases plus random traffic against a scoreboard.
// A second instance with fixed priority shares the stimulus.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, fp_req_ready;
  logic [31:0] req_data0, req_data1;
  logic [4:0]  req_amt0, req_amt1;
  logic [1:0]  req_op0, req_op1;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;
  logic        fp_resp_valid, fp_resp_id;
  logic [31:0] fp_resp_data;

  always #5 clk = ~clk;

  shift_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1), .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_op0(req_op0), .req_op1(req_op1), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  shift_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_data0(req_data0), .req_data1(req_data1), .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_op0(req_op0), .req_op1(req_op1), .resp_valid(fp_resp_valid), .resp_ready(resp_ready),
    .resp_data(fp_resp_data), .resp_id(fp_resp_id)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] fp_q[$];
  int          acc_log[$], new_log[$];
  logic [31:0] pop_log[$];
  logic        id_log[$];
  int          n_checks = 0, n_errors = 0, cyc = 0, fp_pops = 0;
  logic        lptr, prev_hold, prev_valid, prev_took, prev_id;
  logic [31:0] prev_data;
  logic [1:0]  hs;
  bit          fp_track;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] x,
                                         input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} >> n;
    case (op)
      2'd0:    return x >> n;
      2'd1:    return x << n;
      2'd2:    return $signed(x) >>> n;
      default: return d[31:0];
    endcase
  endfunction

  function automatic logic [31:0] port_ref(input int p);
    if (p == 0) return ref_op(req_op0, req_data0, req_amt0);
    return ref_op(req_op1, req_data1, req_amt1);
  endfunction

  task automatic set_port(input int p, input logic [1:0] op, input logic [31:0] x,
                          input logic [4:0] n);
    if (p == 0) begin
      req_op0 = op; req_data0 = x; req_amt0 = n;
    end else begin
      req_op1 = op; req_data1 = x; req_amt1 = n;
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); new_log.delete(); pop_log.delete(); id_log.delete();
  endtask

  // Samples one cycle just after the inputs settle, updates the model, then steps to the next negedge.
  task automatic tick();
    int   w;
    exp_t e;
    #1;
    hs = 2'b00;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      sb_q.delete(); fp_q.delete();
      lptr = 1'b1; prev_hold = 1'b0; prev_valid = 1'b0; prev_took = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", resp_data, prev_data);
        chk("hold_id", 32'(resp_id), 32'(prev_id));
      end
      if (resp_valid && (!prev_valid || prev_took)) new_log.push_back(cyc);
      if (req_ready != 2'b00) begin
        if (&req_valid) w = lptr ? 0 : 1;
        else            w = req_valid[1] ? 1 : 0;
        chk("grant_rr", 32'(req_ready), 32'(2'b01 << w));
      end
      if (fp_req_ready != 2'b00) chk("grant_fp", 32'(fp_req_ready), req_valid[0] ? 32'd1 : 32'd2);
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          hs[p] = 1'b1;
          e.id = (p == 1);
          e.data = port_ref(p);
          sb_q.push_back(e);
          acc_log.push_back(cyc);
          lptr = (p == 1);
        end
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_id", 32'(resp_id), 32'(e.id));
        end
        pop_log.push_back(resp_data);
        id_log.push_back(resp_id);
      end
      if (fp_track) begin
        if (fp_req_ready[0] && req_valid[0]) fp_q.push_back(port_ref(0));
        if (fp_resp_valid && resp_ready && fp_q.size() != 0) begin
          chk("fp_data", fp_resp_data, fp_q.pop_front());
          chk("fp_id", 32'(fp_resp_id), 32'd0);
          fp_pops++;
        end
      end
      prev_hold  = resp_valid && !resp_ready;
      prev_valid = resp_valid;
      prev_took  = resp_valid && resp_ready;
      prev_data  = resp_data;
      prev_id    = resp_id;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    for (int t = 0; t < 30 && (sb_q.size() != 0 || resp_valid || fp_resp_valid); t++) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send(input int p, input logic [1:0] op, input logic [31:0] x,
                      input logic [4:0] n, input logic [31:0] exp_d, input int exp_lat,
                      input string tag);
    clear_logs();
    resp_ready = 1'b1;
    set_port(p, op, x, n);
    req_valid = 2'b01 << p;
    hs = 2'b00;
    for (int t = 0; t < 20 && !hs[p]; t++) tick();
    req_valid = 2'b00;
    chk({tag, "_hs"}, 32'(hs[p]), 32'd1);
    drain();
    chk({tag, "_count"}, 32'(pop_log.size()), 32'd1);
    if (pop_log.size() == 1 && new_log.size() > 0 && acc_log.size() > 0) begin
      chk({tag, "_data"}, pop_log[0], exp_d);
      chk({tag, "_id"}, 32'(id_log[0]), 32'(p));
      chk({tag, "_lat"}, 32'(new_log[0] - acc_log[0]), 32'(exp_lat));
    end
  endtask

  initial begin
    logic [31:0] bp_vals [3];
    int          idx;

    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b1; fp_track = 1'b0;
    set_port(0, 2'd0, 32'd0, 5'd0);
    set_port(1, 2'd0, 32'd0, 5'd0);
    lptr = 1'b1; hs = 2'b00; prev_hold = 1'b0; prev_valid = 1'b0; prev_took = 1'b0;
    prev_id = 1'b0; prev_data = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_data", resp_data, 32'd0);
    chk("reset_id", 32'(resp_id), 32'd0);

    send(0, 2'd0, 32'h8000_0000, 5'd31, 32'h0000_0001, 2, "srl31");
    send(1, 2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 2, "sra_neg");
    send(1, 2'd1, 32'h0000_0001, 5'd31, 32'h8000_0000, 2, "sll31");
    send(1, 2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 2, "sra_pos");

    // ROR with a competing request arriving during the first rotate pass
    clear_logs();
    resp_ready = 1'b1;
    set_port(0, 2'd3, 32'h1234_5678, 5'd8);
    req_valid = 2'b01;
    hs = 2'b00;
    for (int t = 0; t < 20 && !hs[0]; t++) tick();
    chk("ror_hs", 32'(hs[0]), 32'd1);
    set_port(1, 2'd0, 32'h0000_00F0, 5'd4);
    req_valid = 2'b10;
    #1 chk("rot_lo_ready", 32'(req_ready), 32'd0);
    tick();
    #1 chk("rot_hi_ready", 32'(req_ready), 32'd2);
    tick();
    drain();
    chk("ror_count", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2 && new_log.size() > 0 && acc_log.size() > 0) begin
      chk("ror_data", pop_log[0], 32'h7812_3456);
      chk("ror_next", pop_log[1], 32'h0000_000F);
      chk("ror_lat", 32'(new_log[0] - acc_log[0]), 32'd3);
    end
    send(1, 2'd3, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 3, "ror0");

    // Both ports saturated: alternation on the RR instance, port 0 only on the fixed one
    clear_logs();
    fp_track = 1'b1; fp_pops = 0;
    resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_port(0, 2'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)));
      set_port(1, 2'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)));
      req_valid = 2'b11;
      #1 chk("fp_ready", 32'(fp_req_ready), 32'd1);
      tick();
    end
    drain();
    fp_track = 1'b0;
    chk("rr_accepts", 32'(acc_log.size()), 32'd12);
    chk("rr_tput", (new_log.size() == 12) ? 32'(new_log[11] - new_log[0]) : 32'hFFFF_FFFF, 32'd11);
    for (int k = 1; k < id_log.size(); k++) chk("rr_alternate", 32'(id_log[k]), 32'(!id_log[k-1]));
    chk("fp_results", 32'(fp_pops), 32'd12);

    // Backpressure with three queued requests
    clear_logs();
    for (int k = 0; k < 3; k++) bp_vals[k] = $urandom;
    resp_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      if (idx < 3) begin
        set_port(0, 2'd0, bp_vals[idx], 5'(idx + 1));
        req_valid = 2'b01;
      end else req_valid = 2'b00;
      tick();
      if (hs[0]) idx++;
    end
    chk("bp_accept_le2", 32'(acc_log.size() <= 2), 32'd1);
    resp_ready = 1'b1;
    for (int t = 0; t < 20 && idx < 3; t++) begin
      set_port(0, 2'd0, bp_vals[idx], 5'(idx + 1));
      req_valid = 2'b01;
      tick();
      if (hs[0]) idx++;
    end
    req_valid = 2'b00;
    chk("bp_all_accepted", 32'(idx), 32'd3);
    drain();
    chk("bp_count", 32'(pop_log.size()), 32'd3);

    // Reset while a rotate is in its second pass
    clear_logs();
    resp_ready = 1'b1;
    set_port(0, 2'd3, $urandom, 5'd5);
    req_valid = 2'b01;
    hs = 2'b00;
    for (int t = 0; t < 20 && !hs[0]; t++) tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_data", resp_data, 32'd0);
    set_port(0, 2'd0, 32'hA5A5_0000, 5'd3);
    set_port(1, 2'd0, 32'h0000_5A5A, 5'd3);
    req_valid = 2'b11;
    #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
    tick();
    drain();
    chk("post_rst_count", 32'(pop_log.size()), 32'd1);
    if (id_log.size() > 0) chk("post_rst_id", 32'(id_log[0]), 32'd0);

    // Random traffic
    clear_logs();
    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
      req_valid  = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      resp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();
    chk("rand_progress", 32'(acc_log.size() > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
